id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline register with load-use hazard detection, bubble insertion, flush and write-back bypass.
- Sits between decode and execute.
- Its ex_rs1/ex_rs2/ex_rd/ex_reg_wr outputs feed the EX-stage forwarding logic and ALU.
- Drives the IF/ID hold signal and keeps a saturating count of load-use bubbles.

Parameters:
XLEN, 32, datapath width of PC, operands and immediate
CNT_W, 16, width of load-use bubble counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2, id_rd  in  5 each  register addresses
id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
id_imm  in  XLEN  decoded immediate
id_alu_op  in  4  ALU operation (alu_op_t)
id_alu_src  in  1  ALU operand B = imm
id_mem_rd, id_mem_wr, id_reg_wr  in  1 each  control
id_wb_sel  in  2  write-back source (wb_sel_t)
wb_reg_wr  in  1  WB stage writes register file this cycle
wb_rd  in  5  WB destination
wb_data  in  XLEN  WB write data
flush  in  1  taken branch/jump resolved in EX
ext_stall  in  1  global freeze (e.g. memory wait)
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered copies
ex_rs1, ex_rs2, ex_rd  out  5 each  registered addresses
ex_alu_op  out  4; ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr  out  1 each; ex_wb_sel  out  2
id_stall  out  1  combinational: hold PC and IF/ID this cycle
lu_bubble_cnt  out  CNT_W  load-use bubbles inserted

Behaviour:
- Reset (rst_n low, async): every registered output and lu_bubble_cnt = 0. Reset mid-stall or mid-flush discards all state; first cycle after release behaves as an empty pipeline.
- Hazard: load_use = id_valid & ex_valid & ex_mem_rd & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- id_stall = load_use & ~flush, combinational. It is not gated by ext_stall.
- WB bypass: each captured operand is wb_data when wb_reg_wr & wb_rd != 0 & wb_rd == id_rsN; otherwise it is id_rsN_data. This covers register-file read-before-write.
- Next-state priority, evaluated at each rising edge:
  1. ext_stall=1: all EX registers and the counter hold, including when flush or load_use are also high.
  2. flush=1: insert bubble.
  3. load_use=1: insert bubble; lu_bubble_cnt += 1, saturating at all-ones (no wrap).
  4. Otherwise: capture ID fields (with WB bypass); ex_valid <= id_valid.
- Bubble: ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr = 0; all other fields = 0. A bubble is therefore ignored by the forwarding logic and by memory.
- If id_valid=0, fields are captured as presented. Consumers must qualify on ex_valid; ex_reg_wr/ex_mem_* are forced 0 when id_valid=0.
- Latency: one cycle ID→EX.
- A load-use stall lasts exactly one cycle: after the bubble, ex_mem_rd=0, so the hazard clears. The stalled instruction enters EX on the next cycle and gets the loaded value via MEM→EX forwarding.
- No state machine beyond the pipeline register; the counter is the only other state.

Decomposition:
- Package pipe_pkg:
  - alu_op_t (4-bit enum), wb_sel_t (2-bit enum: ALU, MEM, PC4, IMM)
  - id_ex_t packed struct of all registered fields
  - localparam REG_ZERO = 5'd0
  - function bubble() returning a zeroed id_ex_t
- Sub-module load_use_detect: combinational hazard equation above, reusable by a later multi-issue decoder.

Test Plan:
1. Reset then normal flow: hold rst_n=0 for 2 cycles → all outputs 0. Release; ID addi x3,x1,5 (id_rd=3, id_imm=5, id_reg_wr=1, id_valid=1) → next cycle ex_rd=3, ex_imm=5, ex_reg_wr=1, ex_valid=1, id_stall=0 throughout.
2. Load-use: EX=lw x5 (ex_mem_rd=1, ex_rd=5); ID add x6,x5,x7 with id_uses_rs1=1 → id_stall=1 that cycle. Next cycle ex_valid=0, ex_reg_wr=0, lu_bubble_cnt=1. Following cycle ex_rd=6, ex_rs1=5, id_stall=0.
3. No false hazard:
   - lw x0 with ID rs1=0 → id_stall=0.
   - lw x5 with ID rs2=5 but id_uses_rs2=0 → id_stall=0.
   - In both cases the counter is unchanged.
4. Flush priority: load_use and flush high together → id_stall=0, next ex_valid=0, counter unchanged. ext_stall=1 for 3 cycles with flush=1 → EX outputs and counter frozen; flush applied on the first cycle after ext_stall drops.
5. WB bypass: wb_reg_wr=1, wb_rd=9, wb_data=0xDEADBEEF, id_rs1=9, id_rs1_data=0x0 → ex_rs1_data=0xDEADBEEF next cycle. Same with wb_rd=0 → ex_rs1_data=0x0.
6. Saturation and async reset: preload via 2^CNT_W+2 load-use events → lu_bubble_cnt=all-ones, no wrap. Assert rst_n low mid-cycle while ext_stall=1 → outputs and counter 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared ID/EX pipeline types, constants and the bubble helper
package pipe_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    // XLEN-wide fields live beside this struct in the stage so XLEN stays a top parameter
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_op_t    alu_op;
        logic       alu_src;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        wb_sel_t    wb_sel;
    } id_ex_t;

    function automatic id_ex_t bubble();
        id_ex_t b;
        b = '0;
        return b;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard between the ID and EX instructions
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_rd,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = id_valid && ex_valid && ex_mem_rd && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbles, flush and WB bypass
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_rd,
    input  logic             id_mem_wr,
    input  logic             id_reg_wr,
    input  logic [1:0]       id_wb_sel,
    input  logic             wb_reg_wr,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    input  logic             ext_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_rd,
    output logic             ex_mem_wr,
    output logic             ex_reg_wr,
    output logic [1:0]       ex_wb_sel,
    output logic             id_stall,
    output logic [CNT_W-1:0] lu_bubble_cnt
);

    id_ex_t            ctrl_d, ctrl_q;
    logic [XLEN-1:0]   pc_d, pc_q;
    logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
    logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
    logic [XLEN-1:0]   imm_d, imm_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              load_use;
    logic              wb_fwd_ok;
    logic [XLEN-1:0]   rs1_byp;
    logic [XLEN-1:0]   rs2_byp;

    load_use_detect u_lud (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ctrl_q.valid),
        .ex_mem_rd   (ctrl_q.mem_rd),
        .ex_rd       (ctrl_q.rd),
        .load_use    (load_use)
    );

    assign id_stall = load_use && !flush;

    // Register file reads before WB writes in the same cycle, so patch the operand here
    assign wb_fwd_ok = wb_reg_wr && (wb_rd != REG_ZERO);
    assign rs1_byp   = (wb_fwd_ok && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
    assign rs2_byp   = (wb_fwd_ok && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;

    always_comb begin
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        cnt_d      = cnt_q;
        if (ext_stall) begin
            // hold everything
        end else if (flush || load_use) begin
            ctrl_d     = bubble();
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            if (!flush && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ctrl_d.valid   = id_valid;
            ctrl_d.rs1     = id_rs1;
            ctrl_d.rs2     = id_rs2;
            ctrl_d.rd      = id_rd;
            ctrl_d.alu_op  = alu_op_t'(id_alu_op);
            ctrl_d.alu_src = id_alu_src;
            ctrl_d.mem_rd  = id_mem_rd && id_valid;
            ctrl_d.mem_wr  = id_mem_wr && id_valid;
            ctrl_d.reg_wr  = id_reg_wr && id_valid;
            ctrl_d.wb_sel  = wb_sel_t'(id_wb_sel);
            pc_d           = id_pc;
            rs1_data_d     = rs1_byp;
            rs2_data_d     = rs2_byp;
            imm_d          = id_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            cnt_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_pc         = pc_q;
    assign ex_rs1_data   = rs1_data_q;
    assign ex_rs2_data   = rs2_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs1        = ctrl_q.rs1;
    assign ex_rs2        = ctrl_q.rs2;
    assign ex_rd         = ctrl_q.rd;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_rd     = ctrl_q.mem_rd;
    assign ex_mem_wr     = ctrl_q.mem_wr;
    assign ex_reg_wr     = ctrl_q.reg_wr;
    assign ex_wb_sel     = ctrl_q.wb_sel;
    assign lu_bubble_cnt = cnt_q;

endmodule
